// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// One access is granted per cycle; read data is routed back to the requester that issued it.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ready,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_valid,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ready,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic [7:0]            busy_cnt
);

    // Handshake: a request transfers on a rising edge where valid && ready.
    // A requester keeps valid and its payload stable until ready; ready is combinational.

    logic                  prio_q, prio_d;          // 0 = R0 favoured, 1 = R1 favoured
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_id_q, pend_id_d;
    logic                  r0_rvalid_q, r0_rvalid_d;
    logic                  r1_rvalid_q, r1_rvalid_d;
    logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            busy_q, busy_d;

    logic                  contended;
    logic                  gnt0, gnt1, gnt_any;
    logic                  gnt_we;

    always_comb begin
        contended = r0_valid && r1_valid;
        gnt0      = rst_n && r0_valid && (!r1_valid || (prio_q == 1'b0));
        gnt1      = rst_n && r1_valid && (!r0_valid || (prio_q == 1'b1));
        gnt_any   = gnt0 || gnt1;

        gnt_we    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (gnt0) begin
            gnt_we  = r0_we;
            addr_d  = r0_addr;
            wdata_d = r0_wdata;
        end else if (gnt1) begin
            gnt_we  = r1_we;
            addr_d  = r1_addr;
            wdata_d = r1_wdata;
        end
    end

    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;
    assign ram_we    = rst_n && gnt_we;
    // Idle cycles keep presenting the last granted address and data.
    assign ram_addr  = addr_d;
    assign ram_wdata = wdata_d;

    always_comb begin
        prio_d = prio_q;
        if (contended && gnt_any) begin
            prio_d = gnt0 ? 1'b1 : 1'b0;
        end

        pend_valid_d = gnt_any && !gnt_we;
        pend_id_d    = gnt1;

        r0_rvalid_d = pend_valid_q && (pend_id_q == 1'b0);
        r1_rvalid_d = pend_valid_q && (pend_id_q == 1'b1);
        r0_rdata_d  = r0_rvalid_d ? ram_rdata : r0_rdata_q;
        r1_rdata_d  = r1_rvalid_d ? ram_rdata : r1_rdata_q;

        busy_d = busy_q;
        if (contended && (busy_q != 8'hFF)) begin
            busy_d = busy_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
        end else begin
            prio_q       <= prio_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            r0_rvalid_q  <= r0_rvalid_d;
            r1_rvalid_q  <= r1_rvalid_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign busy_cnt  = busy_q;

endmodule
